// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
// audio_pkg : shared state encoding and BRAM word-address helpers
// Revision  : 1.0
// ============================================================================
package audio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_e;

  localparam logic [31:0] WORD_BYTES = 32'd4;

  // Byte address of word idx; wraps naturally modulo 2^32.
  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [31:0] idx);
    return base + idx * WORD_BYTES;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// sync_fifo : single-clock FIFO with occupancy count, power-of-two depth
// Revision  : 1.0
// ============================================================================
module sync_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;
  logic             full, do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a full FIFO may still accept.
  assign do_push = push_i && (!full || do_pop);
  assign dout_o  = mem_q[rptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_in) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule
`default_nettype wire

// File: rtl/bram_frame_reader.sv
`default_nettype none
// ============================================================================
// bram_frame_reader : streams one frame of words out of BRAM port B
// Revision          : 1.0
// ============================================================================
module bram_frame_reader
  import audio_pkg::*;
#(
  parameter int FRAME_WORDS = 512,
  parameter int RD_LAT      = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start,
  input  logic [31:0] base_addr,
  output logic        busy,
  output logic        done,
  output logic        rstb,
  output logic        enb,
  output logic [3:0]  web,
  output logic [31:0] addrb,
  output logic [31:0] dinb,
  input  logic [31:0] doutb,
  output logic [31:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last
);

  localparam int IW = $clog2(FRAME_WORDS + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  rd_state_e         state_q, state_d;
  logic [31:0]       base_q, base_d;
  logic [IW-1:0]     issued_q, issued_d;
  logic [IW-1:0]     accepted_q, accepted_d;
  logic [RD_LAT-1:0] vld_q, vld_d;

  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic [CW:0]       outstanding;
  logic              issue, pop;

  assign rstb = 1'b0;
  assign web  = 4'b0;
  assign dinb = 32'b0;

  always_comb begin
    outstanding = '0;
    for (int i = 0; i < RD_LAT; i++) outstanding = outstanding + (CW+1)'(vld_q[i]);
  end

  // Credit = reads in flight plus words buffered; never exceed the FIFO.
  assign issue = (state_q == ST_READ) && (issued_q < IW'(FRAME_WORDS)) &&
                 ((outstanding + (CW+1)'(fifo_count)) < (CW+1)'(FIFO_DEPTH));

  assign enb     = issue;
  assign addrb   = issue ? word_addr(base_q, 32'(issued_q)) : 32'b0;
  assign m_valid = !fifo_empty;
  assign m_last  = m_valid && (accepted_q == IW'(FRAME_WORDS - 1));
  assign pop     = m_valid && m_ready;
  assign busy    = (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign done    = (state_q == ST_DONE);

  always_comb begin
    vld_d[0] = issue;
    for (int i = 1; i < RD_LAT; i++) vld_d[i] = vld_q[i-1];
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    issued_d   = issued_q;
    accepted_d = pop ? accepted_q + IW'(1) : accepted_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d     = base_addr;
          issued_d   = '0;
          accepted_d = '0;
          state_d    = ST_READ;
        end
      end
      ST_READ: begin
        if (issue) begin
          issued_d = issued_q + IW'(1);
          if (issued_q == IW'(FRAME_WORDS - 1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && m_last) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      issued_q   <= '0;
      accepted_q <= '0;
      vld_q      <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      issued_q   <= issued_d;
      accepted_q <= accepted_d;
      vld_q      <= vld_d;
    end
  end

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .push_i  (vld_q[RD_LAT-1]),
    .din_i   (doutb),
    .pop_i   (pop),
    .dout_o  (m_data),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

endmodule
`default_nettype wire
